// File: rtl/mux_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin mux scheduler and its picker.
// The FSM state encoding, channel count and arbitration reset point live here.
package mux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    // Reset to the last channel so that channel 0 is searched first.
    localparam logic [SEL_W-1:0] LAST_GRANT_RST = 2'd3;

endpackage : mux_sched_pkg

// File: rtl/mux_rr_scheduler_if.sv
// Request, mux-select and output-handshake bundle between the scheduler and its surroundings.
// The master side is the scheduler; the slave side is the mux, the requesters and the consumer.
interface mux_rr_scheduler_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [1:0]       sel;
    logic [WIDTH-1:0] mux_out;
    logic [3:0]       ack;
    logic [WIDTH-1:0] dout;
    logic [1:0]       dout_ch;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;

    modport master (
        input  req,
        input  mux_out,
        input  dout_ready,
        output sel,
        output ack,
        output dout,
        output dout_ch,
        output dout_valid,
        output busy
    );

    modport slave (
        output req,
        output mux_out,
        output dout_ready,
        input  sel,
        input  ack,
        input  dout,
        input  dout_ch,
        input  dout_valid,
        input  busy
    );

endinterface : mux_rr_scheduler_if

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: searches last_grant+1, +2, +3, +0 (mod 4)
// and returns the first requesting channel.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_grant,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [N_CH-1:0]  w_rot;
    logic [SEL_W-1:0] w_off;

    // w_rot[k] is the request of the channel k+1 places after last_grant.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
            logic [SEL_W-1:0] w_idx;
            assign w_idx      = last_grant + SEL_W'(gi + 1);
            assign w_rot[gi]  = req[w_idx];
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
    end

    assign winner  = last_grant + SEL_W'(1) + w_off;
    assign any_req = |req;

endmodule : rr_pick

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the select of an external 4:1 mux and capturing
// the selected data, with its channel ID, into a valid/ready output register.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_scheduler_if.master  bus
);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last_grant;
    logic [SEL_W-1:0] r_dout_ch;
    logic [WIDTH-1:0] r_dout;
    logic [N_CH-1:0]  r_ack;
    logic             r_dout_valid;

    logic [SEL_W-1:0] w_winner;
    logic             w_any_req;
    logic [N_CH-1:0]  w_sel_onehot;

    rr_pick u_rr_pick (
        .req        (bus.req),
        .last_grant (r_last_grant),
        .winner     (w_winner),
        .any_req    (w_any_req)
    );

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
            assign w_sel_onehot[gi] = (r_sel == SEL_W'(gi));
        end
    endgenerate

    // ack is a single-cycle pulse: cleared every cycle unless set on SETTLE exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_last_grant <= LAST_GRANT_RST;
            r_dout_ch    <= '0;
            r_dout       <= '0;
            r_ack        <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_sel   <= w_winner;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_dout       <= bus.mux_out;
                    r_dout_ch    <= r_sel;
                    r_dout_valid <= 1'b1;
                    r_ack        <= w_sel_onehot;
                    r_last_grant <= r_sel;
                    r_state      <= OUTPUT;
                end
                OUTPUT: begin
                    if (bus.dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_dout_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.ack        = r_ack;
    assign bus.dout       = r_dout;
    assign bus.dout_ch    = r_dout_ch;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = (r_state != IDLE);

endmodule : mux_rr_scheduler

// File: tb/tb_mux_rr_scheduler.sv
// Directed self-checking bench for mux_rr_scheduler with a 4:1 mux model
// whose inputs are fixed at 5, 6, 7, 8.
module tb_mux_rr_scheduler;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mux_rr_scheduler_if #(.WIDTH(WIDTH)) bus ();

    mux_rr_scheduler #(.WIDTH(WIDTH), .N_CH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External combinational mux: in0..in3 = 5, 6, 7, 8.
    assign bus.mux_out = (bus.sel == 2'd0) ? 4'd5 :
                         (bus.sel == 2'd1) ? 4'd6 :
                         (bus.sel == 2'd2) ? 4'd7 : 4'd8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full grant with dout_ready already high: SETTLE, OUTPUT, back to IDLE.
    task automatic do_item(input logic [1:0] ch, input logic [3:0] data);
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << ch;
        tick();
        check("settle_sel",   32'(bus.sel), 32'(ch));
        check("settle_busy",  32'(bus.busy), 32'd1);
        check("settle_valid", 32'(bus.dout_valid), 32'd0);
        check("settle_ack",   32'(bus.ack), 32'd0);
        tick();
        check("out_dout",  32'(bus.dout), 32'(data));
        check("out_ch",    32'(bus.dout_ch), 32'(ch));
        check("out_valid", 32'(bus.dout_valid), 32'd1);
        check("out_ack",   32'(bus.ack), 32'(exp_ack));
        $display("item ch=%0d dout=%0d ack=%b", bus.dout_ch, bus.dout, bus.ack);
        tick();
        check("idle_valid", 32'(bus.dout_valid), 32'd0);
        check("idle_ack",   32'(bus.ack), 32'd0);
        check("idle_busy",  32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.req        = 4'b0000;
        bus.dout_ready = 1'b0;
        tick();
        tick();
        check("rst_sel",   32'(bus.sel), 32'd0);
        check("rst_ack",   32'(bus.ack), 32'd0);
        check("rst_dout",  32'(bus.dout), 32'd0);
        check("rst_ch",    32'(bus.dout_ch), 32'd0);
        check("rst_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full contention from reset: 0,1,2,3,0.
        bus.req        = 4'b1111;
        bus.dout_ready = 1'b1;
        do_item(2'd0, 4'd5);
        do_item(2'd1, 4'd6);
        do_item(2'd2, 4'd7);
        do_item(2'd3, 4'd8);
        do_item(2'd0, 4'd5);
        bus.req = 4'b0000;

        // Single request on ch2.
        tick();
        bus.req = 4'b0100;
        do_item(2'd2, 4'd7);
        bus.req = 4'b0000;
        tick();
        check("single_sel_hold", 32'(bus.sel), 32'd2);
        check("single_busy",     32'(bus.busy), 32'd0);

        // Sparse round-robin: grant ch1, then alternate 3,1,3.
        bus.req = 4'b0010;
        do_item(2'd1, 4'd6);
        bus.req = 4'b1010;
        do_item(2'd3, 4'd8);
        do_item(2'd1, 4'd6);
        do_item(2'd3, 4'd8);
        bus.req = 4'b0000;
        tick();

        // Back-pressure on ch0 (last_grant=3).
        bus.req        = 4'b0001;
        bus.dout_ready = 1'b0;
        tick();
        check("bp_sel", 32'(bus.sel), 32'd0);
        tick();
        check("bp_dout",  32'(bus.dout), 32'd5);
        check("bp_valid", 32'(bus.dout_valid), 32'd1);
        check("bp_ack",   32'(bus.ack), 32'b0001);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_dout",  32'(bus.dout), 32'd5);
            check("bp_hold_ch",    32'(bus.dout_ch), 32'd0);
            check("bp_hold_sel",   32'(bus.sel), 32'd0);
            check("bp_hold_valid", 32'(bus.dout_valid), 32'd1);
            check("bp_hold_ack",   32'(bus.ack), 32'd0);
            check("bp_hold_busy",  32'(bus.busy), 32'd1);
        end
        bus.dout_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.dout_valid), 32'd0);
        check("bp_release_busy",  32'(bus.busy), 32'd0);
        $display("item ch=0 dout=5 released after back-pressure");
        do_item(2'd1, 4'd6);
        bus.req = 4'b0000;

        // Idle: nothing moves.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy_run",  32'(bus.busy), 32'd0);
            check("idle_ack_run",   32'(bus.ack), 32'd0);
            check("idle_sel_run",   32'(bus.sel), 32'd1);
        end

        // Reset in the middle of OUTPUT (last_grant=1 -> ch2).
        bus.req        = 4'b1111;
        bus.dout_ready = 1'b0;
        tick();
        check("mid_sel", 32'(bus.sel), 32'd2);
        tick();
        check("mid_valid", 32'(bus.dout_valid), 32'd1);
        check("mid_dout",  32'(bus.dout), 32'd7);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.dout_valid), 32'd0);
        check("async_sel",   32'(bus.sel), 32'd0);
        check("async_ack",   32'(bus.ack), 32'd0);
        check("async_busy",  32'(bus.busy), 32'd0);
        tick();
        check("rst_hold_ack", 32'(bus.ack), 32'd0);
        rst_n          = 1'b1;
        bus.dout_ready = 1'b1;
        do_item(2'd0, 4'd5);
        bus.req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux_rr_scheduler

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that sits directly upstream of the 4:1 nibble mux and drives its 2-bit select.
- Arbitrates four channel requests and steers the winning channel through the mux.
- Registers the mux result together with the channel ID into an output holding register with a valid/ready handshake.
- The mux itself stays combinational and external; this block owns sequencing, fairness and back-pressure.

Parameters:
- WIDTH, 4, data width of each mux input/output.
- N_CH, 4, number of channels; fixed at 4, matching the 2-bit select.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  4  per-channel request, level; bit i = channel i has data on mux input i
- sel  out  2  select to the mux (its se1 input); registered
- mux_out  in  WIDTH  combinational mux output (its out1)
- ack  out  4  one-hot, one-cycle pulse; channel whose data was captured
- dout  out  WIDTH  captured data
- dout_ch  out  2  channel index of dout
- dout_valid  out  1  dout/dout_ch hold a valid item
- dout_ready  in  1  downstream accepts when dout_valid && dout_ready
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, sel=0, ack=0, dout=0, dout_ch=0, dout_valid=0, last_grant=3.
  - last_grant=3 gives channel 0 first priority.
  - Reset mid-operation discards any in-flight or held item; no ack is issued for it.
- States:
  - IDLE: if req != 0, pick winner by search order last_grant+1, +2, +3, +0 (mod 4); sel<=winner; go SETTLE. If req == 0, stay in IDLE with sel unchanged.
  - SETTLE: one cycle for mux_out to settle on the new sel. At the end of the cycle: dout<=mux_out, dout_ch<=sel, dout_valid<=1, ack[sel]<=1 (pulse for the next cycle only), last_grant<=sel; go OUTPUT.
  - OUTPUT: hold dout, dout_ch, sel. When dout_ready=1: dout_valid<=0 and go IDLE. When dout_ready=0: stay, all outputs stable.
- Latency and throughput:
  - req seen in IDLE at edge N -> sel valid after N.
  - dout_valid=1 and ack pulse after edge N+1.
  - Best case is one item per 3 cycles (ready held high).
- Request rules:
  - req is sampled only in IDLE.
  - A requester that drops req during SETTLE is still captured and acked.
  - Requests arriving during SETTLE or OUTPUT wait for the next IDLE.
- Fairness: a continuously requesting channel is served at most once per 4 grants when all four request.
- Wrap-around: last_grant=3 -> search starts at channel 0; 2-bit arithmetic wraps naturally.
- Simultaneous events: dout_ready=1 in the same cycle OUTPUT is entered completes the handshake at that edge, so dout_valid is high for exactly one cycle.
- ack timing: ack is never high while state == IDLE, except the pulse cycle that overlaps OUTPUT entry.

Decomposition:
- Shared package (mux_sched_pkg):
  - state enum {IDLE, SETTLE, OUTPUT}
  - constants N_CH=4, SEL_W=2
  - reset value LAST_GRANT_RST=2'd3
- Sub-module rr_pick: combinational picker. Inputs req[3:0] and last_grant[1:0]; outputs winner[1:0] and any_req. Reusable by other arbiters in the design.

Test Plan:
- Bench instantiates the existing mux with in0..in3 = 5, 6, 7, 8, and connects sel/mux_out.
- Single request: req=0100 held, dout_ready=1 -> sel=2 one cycle after req sampled; dout=7, dout_ch=2, dout_valid=1 and ack=0100 one cycle later; ack high exactly 1 cycle; busy returns 0.
- Full contention: req=1111 constant, dout_ready=1 -> accepted sequence (ch,dout) = (0,5), (1,6), (2,7), (3,8), (0,5); one item every 3 cycles.
- Sparse round-robin: preload last_grant=1 via a prior grant on ch1, then req=1010 -> grant ch3 (dout=8), then ch1 (dout=6), then ch3.
- Back-pressure: item ch0 (dout=5) valid, dout_ready=0 for 5 cycles -> dout, dout_ch, sel, dout_valid stable; no ack; req changes ignored. Raise ready -> handshake completes at that edge; next grant follows.
- Idle and reset: req=0000 for 10 cycles -> state IDLE, busy=0, sel unchanged, no ack. Assert rst_n=0 mid-OUTPUT with dout_valid=1 -> dout_valid=0, sel=0 immediately (async). After release with req=1111 -> first grant is ch0.
